sprite_pos_regs: RTL and testbench
==================================

SPRITE_POS_REGS -- requirements
Module: sprite_pos_regs

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 5, number of sprite x/y pairs.
REQ-002 SHALL have parameter VACTIVE, default 480, first non-visible line.
REQ-003 SHALL have port clk  input  1  system clock (50 MHz, same as the VGA counters).
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port chipselect  input  1  Avalon-MM select.
REQ-006 SHALL have port write  input  1  Avalon-MM write strobe.
REQ-007 SHALL have port read  input  1  Avalon-MM read strobe.
REQ-008 SHALL have port address  input  9  Avalon-MM word address.
REQ-009 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-010 SHALL have port readdata  output  32  Avalon-MM read data, registered.
REQ-011 SHALL have port hcount  input  11  horizontal count from the VGA counters.
REQ-012 SHALL have port vcount  input  10  vertical count from the VGA counters.
REQ-013 SHALL have port act_x  output  NUM_SLOTS*11  active x per slot; slot i at [11i+10:11i].
REQ-014 SHALL have port act_y  output  NUM_SLOTS*10  active y per slot; slot i at [10i+9:10i].
REQ-015 SHALL have port irq  output  1  vblank interrupt, level, active-high.

Function
REQ-016 SHALL hold two banks per slot, shadow (written by the bus) and active (drives act_x/act_y).
REQ-017 SHALL map addresses 2i to slot i x, writedata[10:0]; and 2i+1 to slot i y, writedata[9:0]; upper bits ignored.
REQ-018 SHALL map address 16 to CTRL: bit0 AUTO (r/w); bit1 COMMIT (write-1 sets pending, reads 0).
REQ-019 SHALL map address 17 to STATUS (read-only): bit0 pending, bit1 dirty, bit2 in_vblank, bit3 irq, [31:16] frame count.
REQ-020 SHALL map address 18 to IRQ_CLR: any write clears irq.
REQ-021 SHALL ignore writes to unmapped addresses and return 0 on reads of them.
REQ-022 SHALL present readdata exactly one cycle after a chipselect&&read cycle; shadow values are returned for position addresses.
REQ-023 SHALL set dirty on any position write; dirty SHALL clear on commit.
REQ-024 SHALL generate a one-cycle vblank_start event when hcount==0 and vcount==VACTIVE.
REQ-025 SHALL commit all shadow values to the active bank on vblank_start when (AUTO==1 and dirty) or pending; pending SHALL clear on commit.
REQ-026 SHALL NOT change act_x/act_y on any cycle other than a commit.
REQ-027 A position write on the vblank_start cycle SHALL land in shadow only; active SHALL take the pre-write shadow value, and dirty SHALL remain set.
REQ-028 A COMMIT write on the vblank_start cycle SHALL set pending for the next vblank_start, not the current one.
REQ-029 in_vblank SHALL equal (vcount >= VACTIVE).
REQ-030 The frame count SHALL increment by 1 on every vblank_start and wrap from 16'hFFFF to 0.
REQ-031 Commit SHALL use no bus handshake; writes are always accepted with zero wait states.

Reset
REQ-032 While reset is high, all shadow and active x SHALL be 100+100*i (mod 2048), and all shadow and active y SHALL be 100.
REQ-033 While reset is high, AUTO SHALL be 1; pending, dirty, irq, frame count and readdata SHALL be 0.
REQ-034 A reset asserted mid-frame SHALL discard uncommitted shadow writes and pending, with no commit on the first vblank_start after release unless the bus requests one.

Configuration
REQ-035 With macro SPRITE_POS_IRQ_EN defined, irq SHALL set on vblank_start, clear on an IRQ_CLR write, and set-on-vblank_start SHALL win over a simultaneous clear.
REQ-036 Without SPRITE_POS_IRQ_EN, irq SHALL be tied to 0, STATUS bit3 SHALL read 0, and IRQ_CLR writes SHALL be ignored.

Verification
REQ-037 Reset, then read addr 0 and 1 -> readdata 100 and 100 one cycle after each read; act_x slot0 = 100.
REQ-038 AUTO=1, write addr 2 = 0x3FF mid-frame -> act_x slot1 unchanged until hcount=0/vcount=480, then 0x3FF; dirty clears.
REQ-039 Write CTRL=0 (AUTO off), write addr 1 = 300 -> no change across two vblanks; write CTRL=2 -> act_y slot0 = 300 at the next vblank_start, pending 0.
REQ-040 Write addr 0 = 50 on the vblank_start cycle, with shadow previously 40 -> act_x slot0 = 40, dirty=1; next vblank -> 50.
REQ-041 With SPRITE_POS_IRQ_EN: irq rises at vblank_start; IRQ_CLR write -> irq 0 next cycle; clear coincident with vblank_start -> irq stays 1.
REQ-042 Run 65536 frames -> frame count reads 0; write addr 200 -> no state change, and a read of it returns 0.

Source files
------------

// File: rtl/sprite_pos_regs_if.sv
// Avalon-MM bus bundle for the sprite position register block.
// The slave modport is taken by sprite_pos_regs; the master side drives the bus.
interface sprite_pos_regs_if;
   logic        chipselect;
   logic        write;
   logic        read;
   logic [8:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output chipselect, write, read, address, writedata,
      input  readdata
   );

   modport slave (
      input  chipselect, write, read, address, writedata,
      output readdata
   );
endinterface

// File: rtl/sprite_pos_regs.sv
// Double-banked sprite x/y registers: the bus writes a shadow bank that is copied to the
// active bank at vblank start. Optional vblank interrupt enabled by macro SPRITE_POS_IRQ_EN.
module sprite_pos_regs #(
   parameter int NUM_SLOTS = 5,
   parameter int VACTIVE   = 480
) (
   input  logic                     clk,
   input  logic                     reset,
   sprite_pos_regs_if.slave         bus,
   input  logic [10:0]              hcount,
   input  logic [9:0]               vcount,
   output logic [NUM_SLOTS*11-1:0]  act_x,
   output logic [NUM_SLOTS*10-1:0]  act_y,
   output logic                     irq
);

   localparam logic [8:0] ADDR_CTRL    = 9'd16;
   localparam logic [8:0] ADDR_STATUS  = 9'd17;
   localparam logic [8:0] ADDR_IRQ_CLR = 9'd18;

   // Reset x position of a slot: 100 + 100*slot, wrapped to 11 bits.
   function automatic logic [10:0] reset_x(input int slot);
      int v;
      v = 32'sd100 + (32'sd100 * slot);
      return v[10:0];
   endfunction

   logic [10:0] shadow_x_q [NUM_SLOTS];
   logic [10:0] shadow_x_d [NUM_SLOTS];
   logic [9:0]  shadow_y_q [NUM_SLOTS];
   logic [9:0]  shadow_y_d [NUM_SLOTS];
   logic [10:0] act_x_q    [NUM_SLOTS];
   logic [10:0] act_x_d    [NUM_SLOTS];
   logic [9:0]  act_y_q    [NUM_SLOTS];
   logic [9:0]  act_y_d    [NUM_SLOTS];

   logic        auto_q,     auto_d;
   logic        pending_q,  pending_d;
   logic        dirty_q,    dirty_d;
   logic        irq_q,      irq_d;
   logic [15:0] frame_q,    frame_d;
   logic [31:0] readdata_q, readdata_d;

   logic        wr_s;
   logic        pos_wr_s;
   logic        ctrl_wr_s;
   logic        vblank_start_s;
   logic        in_vblank_s;
   logic        commit_s;
   logic [31:0] rd_pos_s;
   logic [31:0] rd_val_s;
   logic        unused_s;

   assign wr_s           = bus.chipselect && bus.write;
   assign pos_wr_s       = wr_s && (bus.address < 9'(32'sd2 * NUM_SLOTS));
   assign ctrl_wr_s      = wr_s && (bus.address == ADDR_CTRL);
   assign vblank_start_s = (hcount == 11'd0) && (vcount == 10'(VACTIVE));
   assign in_vblank_s    = (vcount >= 10'(VACTIVE));
   // Decision uses registered flags only, so a same-cycle bus write affects the next vblank.
   assign commit_s       = vblank_start_s && ((auto_q && dirty_q) || pending_q);
   assign unused_s       = ^bus.writedata[31:11];

`ifdef SPRITE_POS_IRQ_EN
   logic irq_clr_s;
   assign irq_clr_s = wr_s && (bus.address == ADDR_IRQ_CLR);
`endif

   always_comb begin
      rd_pos_s = 32'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         rd_pos_s = rd_pos_s
                  | ((bus.address == 9'(32'sd2 * i))
                       ? {21'd0, shadow_x_q[i]} : 32'd0)
                  | ((bus.address == 9'((32'sd2 * i) + 32'sd1))
                       ? {22'd0, shadow_y_q[i]} : 32'd0);
      end
      case (bus.address)
         ADDR_CTRL:    rd_val_s = {31'd0, auto_q};
         ADDR_STATUS:  rd_val_s = {frame_q, 12'd0, irq_q, in_vblank_s, dirty_q, pending_q};
         ADDR_IRQ_CLR: rd_val_s = 32'd0;
         default:      rd_val_s = rd_pos_s;
      endcase
   end

   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         shadow_x_d[i] = (wr_s && (bus.address == 9'(32'sd2 * i)))
                       ? bus.writedata[10:0] : shadow_x_q[i];
         shadow_y_d[i] = (wr_s && (bus.address == 9'((32'sd2 * i) + 32'sd1)))
                       ? bus.writedata[9:0] : shadow_y_q[i];
         act_x_d[i]    = commit_s ? shadow_x_q[i] : act_x_q[i];
         act_y_d[i]    = commit_s ? shadow_y_q[i] : act_y_q[i];
      end

      if (ctrl_wr_s) begin
         auto_d = bus.writedata[0];
      end else begin
         auto_d = auto_q;
      end

      // A set request in the same cycle as a commit survives for the following vblank.
      if (ctrl_wr_s && bus.writedata[1]) begin
         pending_d = 1'b1;
      end else if (commit_s) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end

      if (pos_wr_s) begin
         dirty_d = 1'b1;
      end else if (commit_s) begin
         dirty_d = 1'b0;
      end else begin
         dirty_d = dirty_q;
      end

`ifdef SPRITE_POS_IRQ_EN
      if (vblank_start_s) begin
         irq_d = 1'b1;
      end else if (irq_clr_s) begin
         irq_d = 1'b0;
      end else begin
         irq_d = irq_q;
      end
`else
      irq_d = 1'b0;
`endif

      frame_d    = vblank_start_s ? (frame_q + 16'd1) : frame_q;
      readdata_d = (bus.chipselect && bus.read) ? rd_val_s : readdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            shadow_x_q[i] <= reset_x(i);
            shadow_y_q[i] <= 10'd100;
            act_x_q[i]    <= reset_x(i);
            act_y_q[i]    <= 10'd100;
         end
         auto_q     <= 1'b1;
         pending_q  <= 1'b0;
         dirty_q    <= 1'b0;
         irq_q      <= 1'b0;
         frame_q    <= 16'd0;
         readdata_q <= 32'd0;
      end else begin
         shadow_x_q <= shadow_x_d;
         shadow_y_q <= shadow_y_d;
         act_x_q    <= act_x_d;
         act_y_q    <= act_y_d;
         auto_q     <= auto_d;
         pending_q  <= pending_d;
         dirty_q    <= dirty_d;
         irq_q      <= irq_d;
         frame_q    <= frame_d;
         readdata_q <= readdata_d;
      end
   end

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_out
      assign act_x[11*g +: 11] = act_x_q[g];
      assign act_y[10*g +: 10] = act_y_q[g];
   end

   assign bus.readdata = readdata_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_sprite_pos_regs.sv
// Directed bench for sprite_pos_regs; expectations follow the SPRITE_POS_IRQ_EN build setting.
module tb_sprite_pos_regs;

`ifdef SPRITE_POS_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [54:0] act_x;
   logic [49:0] act_y;
   logic        irq;

   int          tests;
   int          failed;
   logic [15:0] exp_frame;
   logic        exp_irq;
   logic [31:0] rd;

   sprite_pos_regs_if bus_if ();

   sprite_pos_regs #(.NUM_SLOTS(5), .VACTIVE(480)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus_if),
      .hcount (hcount),
      .vcount (vcount),
      .act_x  (act_x),
      .act_y  (act_y),
      .irq    (irq)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] st(input logic [15:0] f, input logic i, input logic v,
                                      input logic d, input logic p);
      return {f, 12'd0, i, v, d, p};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid_frame();
      hcount = 11'd300;
      vcount = 10'd100;
   endtask

   task automatic bus_write(input logic [8:0] a, input logic [31:0] d);
      bus_if.chipselect = 1'b1;
      bus_if.write      = 1'b1;
      bus_if.address    = a;
      bus_if.writedata  = d;
      tick();
      bus_if.chipselect = 1'b0;
      bus_if.write      = 1'b0;
   endtask

   task automatic bus_read(input logic [8:0] a, output logic [31:0] d);
      bus_if.chipselect = 1'b1;
      bus_if.read       = 1'b1;
      bus_if.address    = a;
      tick();
      d = bus_if.readdata;
      bus_if.chipselect = 1'b0;
      bus_if.read       = 1'b0;
   endtask

   // One vblank_start cycle, optionally with a simultaneous bus write.
   task automatic vblank(input logic with_wr, input logic [8:0] a, input logic [31:0] d);
      hcount = 11'd0;
      vcount = 10'd480;
      if (with_wr) begin
         bus_write(a, d);
      end else begin
         tick();
      end
      exp_frame = exp_frame + 16'd1;
      exp_irq   = IRQ_ON;
      mid_frame();
   endtask

   task automatic clear_irq();
      bus_write(9'd18, 32'd0);
      exp_irq = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      tests++;
      if (act_x !== {11'd500, 11'd400, 11'd300, 11'd200, 11'd100}) begin
         failed++; $display("FAIL reset_act_x got %h want %h", act_x, {11'd500, 11'd400, 11'd300, 11'd200, 11'd100});
      end
      tests++;
      if (act_y !== {5{10'd100}}) begin
         failed++; $display("FAIL reset_act_y got %h want %h", act_y, {5{10'd100}});
      end
      tests++;
      if (irq !== 1'b0 || bus_if.readdata !== 32'd0) begin
         failed++; $display("FAIL reset_irq_rd got irq=%b rd=%h want 0/0", irq, bus_if.readdata);
      end
      reset = 1'b0;
      exp_frame = 16'd0;
      exp_irq = 1'b0;
      bus_read(9'd0, rd);
      tests++;
      if (rd !== 32'd100) begin failed++; $display("FAIL rd_x0 got %0d want 100", rd); end
      bus_read(9'd1, rd);
      tests++;
      if (rd !== 32'd100) begin failed++; $display("FAIL rd_y0 got %0d want 100", rd); end
      tests++;
      if (act_x[10:0] !== 11'd100) begin failed++; $display("FAIL act_x0 got %0d want 100", act_x[10:0]); end
      bus_read(9'd16, rd);
      tests++;
      if (rd !== 32'd1) begin failed++; $display("FAIL rd_ctrl got %h want 1", rd); end
      bus_read(9'd17, rd);
      tests++;
      if (rd !== 32'd0) begin failed++; $display("FAIL rd_status got %h want 0", rd); end
   endtask

   task automatic test_auto_commit();
      bus_write(9'd2, 32'hFFFF_FBFF);
      tick();
      tests++;
      if (act_x[21:11] !== 11'd200) begin failed++; $display("FAIL auto_hold got %h want %h", act_x[21:11], 11'd200); end
      bus_read(9'd17, rd);
      tests++;
      if (rd !== st(exp_frame, 1'b0, 1'b0, 1'b1, 1'b0)) begin failed++; $display("FAIL auto_dirty got %h", rd); end
      hcount = 11'd5;
      vcount = 10'd480;
      bus_read(9'd17, rd);
      tests++;
      if (rd !== st(exp_frame, 1'b0, 1'b1, 1'b1, 1'b0) || act_x[21:11] !== 11'd200) begin
         failed++; $display("FAIL in_vblank got %h x1=%h", rd, act_x[21:11]);
      end
      mid_frame();
      vblank(1'b0, 9'd0, 32'd0);
      tests++;
      if (act_x[21:11] !== 11'h3FF) begin failed++; $display("FAIL auto_commit got %h want 3ff", act_x[21:11]); end
      bus_read(9'd17, rd);
      tests++;
      if (rd !== st(exp_frame, exp_irq, 1'b0, 1'b0, 1'b0)) begin
         failed++; $display("FAIL auto_status got %h want %h", rd, st(exp_frame, exp_irq, 1'b0, 1'b0, 1'b0));
      end
      clear_irq();
   endtask

   task automatic test_manual_commit();
      bus_write(9'd16, 32'd0);
      bus_write(9'd1, 32'd300);
      vblank(1'b0, 9'd0, 32'd0);
      vblank(1'b0, 9'd0, 32'd0);
      tests++;
      if (act_y[9:0] !== 10'd100) begin failed++; $display("FAIL manual_hold got %0d want 100", act_y[9:0]); end
      clear_irq();
      bus_write(9'd16, 32'd2);
      bus_read(9'd16, rd);
      tests++;
      if (rd !== 32'd0) begin failed++; $display("FAIL ctrl_commit_rd got %h want 0", rd); end
      bus_read(9'd17, rd);
      tests++;
      if (rd !== st(exp_frame, 1'b0, 1'b0, 1'b1, 1'b1)) begin failed++; $display("FAIL pending_set got %h", rd); end
      vblank(1'b0, 9'd0, 32'd0);
      tests++;
      if (act_y[9:0] !== 10'd300) begin failed++; $display("FAIL manual_commit got %0d want 300", act_y[9:0]); end
      bus_read(9'd17, rd);
      tests++;
      if (rd !== st(exp_frame, exp_irq, 1'b0, 1'b0, 1'b0)) begin failed++; $display("FAIL pending_clr got %h", rd); end
      clear_irq();
   endtask

   task automatic test_vblank_collision();
      bus_write(9'd16, 32'd1);
      bus_write(9'd0, 32'd40);
      tests++;
      if (act_x[10:0] !== 11'd100) begin failed++; $display("FAIL pre_coll got %0d want 100", act_x[10:0]); end
      vblank(1'b1, 9'd0, 32'd50);
      tests++;
      if (act_x[10:0] !== 11'd40) begin failed++; $display("FAIL coll_pos got %0d want 40", act_x[10:0]); end
      bus_read(9'd17, rd);
      tests++;
      if (rd !== st(exp_frame, exp_irq, 1'b0, 1'b1, 1'b0)) begin failed++; $display("FAIL coll_dirty got %h", rd); end
      bus_read(9'd0, rd);
      tests++;
      if (rd !== 32'd50) begin failed++; $display("FAIL coll_shadow got %0d want 50", rd); end
      vblank(1'b0, 9'd0, 32'd0);
      tests++;
      if (act_x[10:0] !== 11'd50) begin failed++; $display("FAIL coll_next got %0d want 50", act_x[10:0]); end
      clear_irq();
      bus_write(9'd16, 32'd0);
      bus_write(9'd1, 32'd77);
      vblank(1'b1, 9'd16, 32'd2);
      tests++;
      if (act_y[9:0] !== 10'd300) begin failed++; $display("FAIL coll_commit_now got %0d want 300", act_y[9:0]); end
      bus_read(9'd17, rd);
      tests++;
      if (rd !== st(exp_frame, exp_irq, 1'b0, 1'b1, 1'b1)) begin failed++; $display("FAIL coll_pending got %h", rd); end
      vblank(1'b0, 9'd0, 32'd0);
      tests++;
      if (act_y[9:0] !== 10'd77) begin failed++; $display("FAIL coll_commit_next got %0d want 77", act_y[9:0]); end
      clear_irq();
   endtask

   task automatic test_irq();
      vblank(1'b0, 9'd0, 32'd0);
      tests++;
      if (irq !== IRQ_ON) begin failed++; $display("FAIL irq_rise got %b want %b", irq, IRQ_ON); end
      bus_read(9'd17, rd);
      tests++;
      if (rd[3] !== IRQ_ON) begin failed++; $display("FAIL irq_status got %b want %b", rd[3], IRQ_ON); end
      clear_irq();
      tests++;
      if (irq !== 1'b0) begin failed++; $display("FAIL irq_clear got %b want 0", irq); end
      vblank(1'b1, 9'd18, 32'd0);
      tests++;
      if (irq !== IRQ_ON) begin failed++; $display("FAIL irq_set_wins got %b want %b", irq, IRQ_ON); end
      clear_irq();
   endtask

   task automatic test_unmapped();
      bus_write(9'd200, 32'hFFFF_FFFF);
      vblank(1'b0, 9'd0, 32'd0);
      tests++;
      if (act_x !== {11'd500, 11'd400, 11'd300, 11'h3FF, 11'd50} ||
          act_y !== {10'd100, 10'd100, 10'd100, 10'd100, 10'd77}) begin
         failed++; $display("FAIL unmapped_act got x=%h y=%h", act_x, act_y);
      end
      bus_read(9'd17, rd);
      tests++;
      if (rd !== st(exp_frame, exp_irq, 1'b0, 1'b0, 1'b0)) begin failed++; $display("FAIL unmapped_status got %h", rd); end
      bus_read(9'd200, rd);
      tests++;
      if (rd !== 32'd0) begin failed++; $display("FAIL unmapped_rd200 got %h want 0", rd); end
      bus_read(9'd10, rd);
      tests++;
      if (rd !== 32'd0) begin failed++; $display("FAIL unmapped_rd10 got %h want 0", rd); end
      bus_read(9'd16, rd);
      tests++;
      if (rd !== 32'd0) begin failed++; $display("FAIL unmapped_ctrl got %h want 0", rd); end
      clear_irq();
   endtask

   task automatic test_reset_mid_frame();
      bus_write(9'd16, 32'd1);
      bus_write(9'd4, 32'd7);
      bus_write(9'd16, 32'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_frame = 16'd0;
      exp_irq = 1'b0;
      vblank(1'b0, 9'd0, 32'd0);
      tests++;
      if (act_x[32:22] !== 11'd300) begin failed++; $display("FAIL rst_mid_act got %0d want 300", act_x[32:22]); end
      bus_read(9'd4, rd);
      tests++;
      if (rd !== 32'd300) begin failed++; $display("FAIL rst_mid_shadow got %0d want 300", rd); end
      bus_read(9'd17, rd);
      tests++;
      if (rd !== st(exp_frame, exp_irq, 1'b0, 1'b0, 1'b0)) begin failed++; $display("FAIL rst_mid_status got %h", rd); end
      clear_irq();
   endtask

   task automatic test_frame_wrap();
      hcount = 11'd0;
      vcount = 10'd480;
      repeat (65534) tick();
      mid_frame();
      bus_read(9'd17, rd);
      tests++;
      if (rd[31:16] !== 16'hFFFF) begin failed++; $display("FAIL frame_ffff got %h want ffff", rd[31:16]); end
      hcount = 11'd0;
      vcount = 10'd480;
      tick();
      mid_frame();
      bus_read(9'd17, rd);
      tests++;
      if (rd[31:16] !== 16'h0000) begin failed++; $display("FAIL frame_wrap got %h want 0", rd[31:16]); end
   endtask

   initial begin
      clk = 1'b0;
      reset = 1'b1;
      tests = 0;
      failed = 0;
      exp_frame = 16'd0;
      exp_irq = 1'b0;
      bus_if.chipselect = 1'b0;
      bus_if.write = 1'b0;
      bus_if.read = 1'b0;
      bus_if.address = 9'd0;
      bus_if.writedata = 32'd0;
      mid_frame();
      test_reset();
      test_auto_commit();
      test_manual_commit();
      test_vblank_collision();
      test_irq();
      test_unmapped();
      test_reset_mid_frame();
      test_frame_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
